fib_dispatch: RTL and testbench
===============================

FIB_DISPATCH -- requirements
Module: fib_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, job FIFO depth; SHALL be a power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 1024, maximum cycles spent in RUN per job; SHALL be 2..65535.
REQ-003 clk  in  1  single clock, all logic on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 job_valid / job_ready  in / out  1 / 1  job request handshake.
REQ-006 job_n, job_a, job_b, job_id  in  6, 32, 32, 4  kernel operands plus caller tag.
REQ-007 res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-008 res_data, res_id, res_timeout  out  32, 4, 1  result, echoed tag, timeout flag.
REQ-009 k_r_enable  out  1  kernel load/start strobe.
REQ-010 k_init_n, k_init_a, k_init_b  out  6, 32, 32  kernel operands.
REQ-011 k_w_enable, k_result  in  1, 32  kernel done level and result.
REQ-012 busy  out  1  high whenever FSM is not IDLE or FIFO is non-empty.
REQ-013 done_count  out  16  completed-job counter, wraps 0xFFFF->0.

Function
REQ-014 A job SHALL be pushed when job_valid&&job_ready; job_ready SHALL equal !fifo_full and SHALL not depend on pops in the same cycle.
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN and RESP.
REQ-016 IDLE->LOAD when FIFO is non-empty; otherwise stay in IDLE.
REQ-017 LOAD SHALL last exactly one cycle: k_r_enable=1, k_init_* driven from the FIFO head, head popped, id latched, RUN counter cleared; then ->RUN.
REQ-018 k_r_enable SHALL be 0 in every state other than LOAD.
REQ-019 k_init_* SHALL hold the last loaded operands outside LOAD.
REQ-020 RUN: counter increments each cycle; k_w_enable=1 -> latch k_result into res_data, res_timeout=0, ->RESP.
REQ-021 RUN: counter==TIMEOUT-1 with k_w_enable=0 -> res_data=0, res_timeout=1, ->RESP; if k_w_enable=1 in the same cycle, success SHALL win.
REQ-022 RESP: res_valid=1 with stable res_data/res_id/res_timeout until res_ready; on handshake done_count+1 and ->IDLE.
REQ-023 Latency: with IDLE and an empty FIFO, k_r_enable SHALL be high 2 cycles after the job handshake cycle.
REQ-024 Latency: res_valid SHALL rise the cycle after k_w_enable is first sampled high in RUN.
REQ-025 Jobs SHALL complete strictly in acceptance order; one job in flight at most.
REQ-026 A push to a full FIFO SHALL NOT occur; a simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 rst_n low SHALL immediately force: FSM=IDLE, FIFO empty, job_ready=0 while rst_n is low, then 1 after release.
REQ-029 rst_n low SHALL also force res_valid=0, res_data=0, res_id=0, res_timeout=0, k_r_enable=0, k_init_*=0, busy=0, done_count=0 and RUN counter=0.
REQ-030 Reset mid-job SHALL discard the in-flight and queued jobs without any response; the kernel is restarted by the next LOAD.

Configuration
REQ-031 With FIB_DISPATCH_TIMEOUT_EN defined, REQ-021 SHALL apply.
REQ-032 With FIB_DISPATCH_TIMEOUT_EN undefined, no RUN counter SHALL exist, RUN SHALL wait on k_w_enable indefinitely, and res_timeout SHALL be tied 0.

Verification
REQ-033 Bench, real kernel attached: one job n=10, a=0, b=1, id=3 -> k_r_enable high 2 cycles after handshake; response res_data=55, res_id=3, res_timeout=0; done_count=1.
REQ-034 Bench: n=0, a=7, b=9 -> res_data=7.
REQ-035 Bench: DEPTH=4, res_ready=0, push 6 jobs back-to-back -> job_ready low after 5 accepts (4 queued + 1 in flight); release res_ready -> results in order ids 0..4, then the 6th job is accepted.
REQ-036 Bench, stub kernel never raising k_w_enable, TIMEOUT=16, macro defined -> res_valid exactly 17 cycles after LOAD, res_timeout=1, res_data=0; macro undefined -> no response within 1000 cycles.
REQ-037 Bench: rst_n pulsed low during RUN with 2 queued jobs -> all outputs at reset values asynchronously, no res_valid after release, busy=0.
REQ-038 Bench: hold res_ready=0 for 5 cycles in RESP -> res_valid, res_data, res_id and res_timeout stable throughout; done_count wraps 0xFFFF->0 after 65536 jobs (force-preloaded counter acceptable).

Source files
------------

// File: rtl/fib_dispatch.sv
// fib_dispatch: FIFO-buffered job dispatcher driving one external Fibonacci kernel at a time.
// Define FIB_DISPATCH_TIMEOUT_EN to bound RUN by TIMEOUT cycles (res_timeout reported).
module fib_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [5:0]  job_n,
  input  logic [31:0] job_a,
  input  logic [31:0] job_b,
  input  logic [3:0]  job_id,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_id,
  output logic        res_timeout,
  output logic        k_r_enable,
  output logic [5:0]  k_init_n,
  output logic [31:0] k_init_a,
  output logic [31:0] k_init_b,
  input  logic        k_w_enable,
  input  logic [31:0] k_result,
  output logic        busy,
  output logic [15:0] done_count
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fib_dispatch: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("fib_dispatch: TIMEOUT must be in 2..65535");
  end

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  typedef struct packed {
    logic [5:0]  n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  id;
  } job_t;

  state_t      r_state, w_next;
  job_t        r_mem [DEPTH];
  job_t        w_head;
  logic [AW:0] r_wptr, r_rptr;
  logic        w_empty, w_full, w_push, w_pop, w_expire;
  logic [5:0]  r_k_n;
  logic [31:0] r_k_a, r_k_b, r_res_data;
  logic [3:0]  r_id;
  logic [15:0] r_done;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty   = r_wptr == r_rptr;
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign job_ready = rst_n && !w_full;
  assign w_push    = job_valid && job_ready;
  assign w_pop     = r_state == LOAD;
  assign w_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= '{n: job_n, a: job_a, b: job_b, id: job_id};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

`ifdef FIB_DISPATCH_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_res_to;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (r_state == LOAD) r_cnt <= '0;
    else if (r_state == RUN) r_cnt <= r_cnt + 16'd1;
  end
  // Success takes priority over an expiry in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_res_to <= 1'b0;
    else if (r_state == RUN && (k_w_enable || w_expire)) r_res_to <= !k_w_enable;
  end
  assign w_expire    = r_cnt == 16'(TIMEOUT - 1);
  assign res_timeout = r_res_to;
`else
  assign w_expire    = 1'b0;
  assign res_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_empty ? IDLE : LOAD;
      LOAD:    w_next = RUN;
      RUN:     w_next = (k_w_enable || w_expire) ? RESP : RUN;
      RESP:    w_next = res_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k_n      <= '0;
      r_k_a      <= '0;
      r_k_b      <= '0;
      r_id       <= '0;
      r_res_data <= '0;
      r_done     <= '0;
    end else begin
      if (r_state == LOAD) begin
        r_k_n <= w_head.n;
        r_k_a <= w_head.a;
        r_k_b <= w_head.b;
        r_id  <= w_head.id;
      end
      if (r_state == RUN && (k_w_enable || w_expire)) r_res_data <= k_w_enable ? k_result : '0;
      if (r_state == RESP && res_ready) r_done <= r_done + 16'd1;
    end
  end

  assign k_r_enable = r_state == LOAD;
  assign k_init_n   = k_r_enable ? w_head.n : r_k_n;
  assign k_init_a   = k_r_enable ? w_head.a : r_k_a;
  assign k_init_b   = k_r_enable ? w_head.b : r_k_b;
  assign res_valid  = r_state == RESP;
  assign res_data   = r_res_data;
  assign res_id     = r_id;
  assign busy       = r_state != IDLE || !w_empty;
  assign done_count = r_done;
endmodule

// File: tb/tb_fib_dispatch.sv
// tb_fib_dispatch: directed bench for fib_dispatch with a behavioural Fibonacci kernel.
// The kernel can be stubbed (never done) to exercise timeout and mid-job reset.
module tb_fib_dispatch;
  logic        clk, rst_n, job_valid, job_ready, res_valid, res_ready, res_timeout;
  logic [5:0]  job_n, k_init_n;
  logic [31:0] job_a, job_b, res_data, k_init_a, k_init_b, k_result;
  logic [3:0]  job_id, res_id;
  logic        k_r_enable, k_w_enable, busy;
  logic [15:0] done_count;
  int          n_checks, n_errors;

  fib_dispatch #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_n(job_n), .job_a(job_a), .job_b(job_b), .job_id(job_id),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .res_timeout(res_timeout),
    .k_r_enable(k_r_enable), .k_init_n(k_init_n), .k_init_a(k_init_a), .k_init_b(k_init_b),
    .k_w_enable(k_w_enable), .k_result(k_result),
    .busy(busy), .done_count(done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  kn;
  logic [31:0] ka, kb;
  logic        kact, stub;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kn <= '0; ka <= '0; kb <= '0; kact <= 1'b0;
    end else if (k_r_enable) begin
      kn <= k_init_n; ka <= k_init_a; kb <= k_init_b; kact <= 1'b1;
    end else if (kact && kn != 6'd0) begin
      kn <= kn - 6'd1; ka <= kb; kb <= ka + kb;
    end
  end
  assign k_w_enable = !stub && kact && kn == 6'd0;
  assign k_result   = ka;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_res_id"}, 32'(res_id), 0);
    chk({tag, "_res_timeout"}, 32'(res_timeout), 0);
    chk({tag, "_k_r_enable"}, 32'(k_r_enable), 0);
    chk({tag, "_k_init_n"}, 32'(k_init_n), 0);
    chk({tag, "_k_init_a"}, k_init_a, 0);
    chk({tag, "_k_init_b"}, k_init_b, 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done_count"}, 32'(done_count), 0);
    chk({tag, "_job_ready"}, 32'(job_ready), 0);
  endtask

  task automatic push(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] id);
    job_n = n; job_a = a; job_b = b; job_id = id; job_valid = 1'b1;
    for (int i = 0; i < 50 && !job_ready; i++) tick();
    chk("push_ready", 32'(job_ready), 1);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic run_job(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] id, input logic [31:0] exp);
    push(n, a, b, id);
    for (int i = 0; i < 200 && !res_valid; i++) tick();
    chk("job_res_valid", 32'(res_valid), 1);
    chk("job_res_data", res_data, exp);
    chk("job_res_id", 32'(res_id), 32'(id));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int acc, got, cyc;
  logic seen;

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; stub = 1'b0; res_ready = 1'b0;
    job_valid = 1'b0; job_n = '0; job_a = '0; job_b = '0; job_id = '0;
    tick(); tick();
    chk_reset("init");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("post_reset_ready", 32'(job_ready), 1);
    chk("post_reset_busy", 32'(busy), 0);

    // fib(10) from (0,1): load latency, RESP latency and held response
    push(6'd10, 32'd0, 32'd1, 4'd3);
    chk("lat_c1_kre", 32'(k_r_enable), 0);
    tick();
    chk("lat_c2_kre", 32'(k_r_enable), 1);
    chk("load_init_n", 32'(k_init_n), 10);
    chk("load_init_b", k_init_b, 1);
    tick();
    chk("run_kre_low", 32'(k_r_enable), 0);
    chk("run_init_hold", 32'(k_init_n), 10);
    for (int i = 0; i < 100 && !k_w_enable; i++) tick();
    chk("kernel_done", 32'(k_w_enable), 1);
    tick();
    chk("lat_res_valid", 32'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_data", res_data, 55);
      chk("hold_id", 32'(res_id), 3);
      chk("hold_timeout", 32'(res_timeout), 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("after_hs_valid", 32'(res_valid), 0);
    chk("done_1", 32'(done_count), 1);

    run_job(6'd0, 32'd7, 32'd9, 4'd5, 32'd7);
    chk("done_2", 32'(done_count), 2);

    // Back-to-back jobs with the result side stalled: 4 queued + 1 in flight
    acc = 0;
    job_n = 6'd2; job_a = 0; job_b = 32'd1; job_id = 0; job_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (job_valid && job_ready) acc++;
      tick();
      job_a = 32'(acc); job_id = 4'(acc);
    end
    chk("fifo_accepts", 32'(acc), 5);
    chk("fifo_full_ready", 32'(job_ready), 0);
    res_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 300 && got < 6; i++) begin
      if (job_valid && job_ready) acc++;
      if (res_valid) begin
        chk("order_id", 32'(res_id), 32'(got));
        chk("order_data", res_data, 32'(got + 1));
        got++;
      end
      tick();
      if (acc >= 6) job_valid = 1'b0;
    end
    res_ready = 1'b0;
    job_valid = 1'b0;
    chk("fifo_results", 32'(got), 6);
    chk("fifo_sixth_accepted", 32'(acc), 6);
    chk("done_8", 32'(done_count), 8);

    // done_count wrap from a preloaded 0xFFFF
    force dut.r_done = 16'hFFFF;
    tick();
    release dut.r_done;
    tick();
    chk("preload", 32'(done_count), 32'hFFFF);
    run_job(6'd1, 32'd4, 32'd6, 4'd9, 32'd6);
    chk("done_wrap", 32'(done_count), 0);

    // Kernel that never finishes
    stub = 1'b1;
    push(6'd3, 32'd1, 32'd1, 4'd7);
    for (int i = 0; i < 20 && !k_r_enable; i++) tick();
    chk("to_load", 32'(k_r_enable), 1);
    cyc = 0;
    while (!res_valid && cyc < 1000) begin
      tick();
      cyc++;
    end
`ifdef FIB_DISPATCH_TIMEOUT_EN
    chk("to_latency", 32'(cyc), 17);
    chk("to_flag", 32'(res_timeout), 1);
    chk("to_data", res_data, 0);
    chk("to_id", 32'(res_id), 7);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    push(6'd5, 32'd11, 32'd12, 4'd1);
`else
    chk("no_response", 32'(res_valid), 0);
    chk("no_response_cycles", 32'(cyc), 1000);
`endif
    push(6'd5, 32'd21, 32'd22, 4'd2);
    push(6'd5, 32'd31, 32'd32, 4'd4);

    // Asynchronous reset mid-RUN with two jobs queued
    tick();
    chk("pre_rst_busy", 32'(busy), 1);
    #3 rst_n = 1'b0;
    #1 chk_reset("midrun");
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | res_valid | busy;
    end
    chk("no_resp_after_rst", 32'(seen), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(job_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
